// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: opcodes, funct codes,
// ALU control codes, controller state encoding and the raw control bundle.
// Used by the controller, the datapath and the testbench.
package mips_pkg;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (IR[5:0])
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  // ALU control codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Controller states, 13 used of 16 encodings
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

  // ALU operation class requested by the FSM; NONE leaves alucontrol at 000
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_NONE  = 2'b11
  } aluop_t;

  // Raw per-state control bundle, before reset gating
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcwrite;
    logic       branch;
    aluop_t     aluop;
    logic       retire;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mips_aludec.sv
// ALU decoder: maps the FSM's ALU operation class plus funct to the
// 3-bit ALU control code, and flags whether an R-type funct is supported.
module mips_aludec
  import mips_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       funct_valid
);

  // Combinational decode; unsupported funct yields 000 and funct_valid=0
  always_comb begin
    alucontrol  = ALU_AND;
    funct_valid = 1'b1;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          F_ADD:   alucontrol = ALU_ADD;
          F_SUB:   alucontrol = ALU_SUB;
          F_AND:   alucontrol = ALU_AND;
          F_OR:    alucontrol = ALU_OR;
          F_SLT:   alucontrol = ALU_SLT;
          default: begin
            alucontrol  = ALU_AND;
            funct_valid = 1'b0;
          end
        endcase
      end
      default: alucontrol = ALU_AND;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over a shared
// ALU and unified memory, counts retired instructions and flags illegal ops.
// Build option MC_HALT_EN: when defined, ILLEGAL is a terminal state left
// only by reset; otherwise ILLEGAL lasts one cycle and fetch resumes.
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic             pcen,
  output logic [2:0]       alucontrol,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             illegal
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl;
  logic [2:0]       dec_alucontrol;
  logic             dec_funct_valid;
  logic             retire_int;

  mips_aludec u_aludec (
    .aluop       (ctrl.aluop),
    .funct       (funct),
    .alucontrol  (dec_alucontrol),
    .funct_valid (dec_funct_valid)
  );

  // State register; reset restarts at FETCH, aborting any instruction in flight
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      // Only lw and sw reach MEMADR, so anything but sw is a load
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   state_d = S_FETCH;
      // Unsupported funct diverts before any register write happens
      S_EXECUTE: state_d = dec_funct_valid ? S_ALUWB : S_ILLEGAL;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
`ifdef MC_HALT_EN
      S_ILLEGAL: state_d = S_ILLEGAL;
`else
      // PC was already advanced in FETCH, so the bad instruction is skipped
      S_ILLEGAL: state_d = S_FETCH;
`endif
      default:   state_d = S_FETCH;
    endcase
  end

  // Moore control decode per state; unlisted controls stay 0
  always_comb begin
    ctrl       = '0;
    ctrl.aluop = ALUOP_NONE;
    case (state_q)
      S_FETCH: begin
        ctrl.irwrite = 1'b1;
        ctrl.alusrcb = 2'b01;
        ctrl.pcwrite = 1'b1;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_DECODE: begin
        ctrl.alusrcb = 2'b11;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.retire   = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
        ctrl.retire   = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.retire   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = 2'b01;
        ctrl.branch  = 1'b1;
        ctrl.retire  = 1'b1;
      end
      S_ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10;
        ctrl.aluop   = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.retire   = 1'b1;
      end
      S_JUMP: begin
        ctrl.pcsrc   = 2'b10;
        ctrl.pcwrite = 1'b1;
        ctrl.retire  = 1'b1;
      end
      S_ILLEGAL: ctrl.illegal = 1'b1;
      default: ctrl = '0;
    endcase
  end

  // Hold every output at 0 while reset is asserted so nothing is written
  assign iord        = ctrl.iord     & ~reset;
  assign memwrite    = ctrl.memwrite & ~reset;
  assign irwrite     = ctrl.irwrite  & ~reset;
  assign regdst      = ctrl.regdst   & ~reset;
  assign memtoreg    = ctrl.memtoreg & ~reset;
  assign regwrite    = ctrl.regwrite & ~reset;
  assign alusrca     = ctrl.alusrca  & ~reset;
  assign alusrcb     = reset ? 2'b00 : ctrl.alusrcb;
  assign pcsrc       = reset ? 2'b00 : ctrl.pcsrc;
  assign pcen        = (ctrl.pcwrite | (ctrl.branch & zero)) & ~reset;
  assign alucontrol  = reset ? 3'b000 : dec_alucontrol;
  assign retire_int  = ctrl.retire   & ~reset;
  assign retire      = retire_int;
  assign illegal     = ctrl.illegal  & ~reset;
  assign retired_cnt = cnt_q;

  // Retire counter next value; wraps naturally at 2^CNT_W
  always_comb begin
    cnt_d = cnt_q;
    if (retire_int) cnt_d = cnt_q + CNT_W'(1);
  end

  // Retire counter register
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed testbench for mips_mc_controller: walks each instruction class
// cycle by cycle and compares state, every control output and the retire
// counter against hand-written expectations. Honours MC_HALT_EN.
module tb_mips_mc_controller;
  import mips_pkg::*;

  localparam int CNT_W = 32;

  logic             clk, reset, zero;
  logic [5:0]       op, funct;
  logic             iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0]       alusrcb, pcsrc;
  logic             pcen, retire, illegal;
  logic [2:0]       alucontrol;
  logic [CNT_W-1:0] retired_cnt;

  int vectors = 0;
  int miscompares = 0;
  logic [CNT_W-1:0] exp_cnt;

  // {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca}_alusrcb_pcsrc_pcen_alucontrol_{retire,illegal}
  localparam logic [16:0] V_ZERO   = 17'b0000000_00_00_0_000_00;
  localparam logic [16:0] V_FETCH  = 17'b0010000_01_00_1_010_00;
  localparam logic [16:0] V_DECODE = 17'b0000000_11_00_0_010_00;
  localparam logic [16:0] V_MEMADR = 17'b0000001_10_00_0_010_00;
  localparam logic [16:0] V_MEMRD  = 17'b1000000_00_00_0_000_00;
  localparam logic [16:0] V_MEMWB  = 17'b0000110_00_00_0_000_10;
  localparam logic [16:0] V_MEMWR  = 17'b1100000_00_00_0_000_10;
  localparam logic [16:0] V_EXADD  = 17'b0000001_00_00_0_010_00;
  localparam logic [16:0] V_EXSLT  = 17'b0000001_00_00_0_111_00;
  localparam logic [16:0] V_EXBAD  = 17'b0000001_00_00_0_000_00;
  localparam logic [16:0] V_ALUWB  = 17'b0001010_00_00_0_000_10;
  localparam logic [16:0] V_BEQT   = 17'b0000001_00_01_1_110_10;
  localparam logic [16:0] V_BEQN   = 17'b0000001_00_01_0_110_10;
  localparam logic [16:0] V_ADDIEX = 17'b0000001_10_00_0_010_00;
  localparam logic [16:0] V_ADDIWB = 17'b0000010_00_00_0_000_10;
  localparam logic [16:0] V_JUMP   = 17'b0000000_00_10_1_000_10;
  localparam logic [16:0] V_ILL    = 17'b0000000_00_00_0_000_01;

  wire [16:0] ctl_vec = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                         alusrcb, pcsrc, pcen, alucontrol, retire, illegal};

  mips_mc_controller #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .op          (op),
    .funct       (funct),
    .zero        (zero),
    .iord        (iord),
    .memwrite    (memwrite),
    .irwrite     (irwrite),
    .regdst      (regdst),
    .memtoreg    (memtoreg),
    .regwrite    (regwrite),
    .alusrca     (alusrca),
    .alusrcb     (alusrcb),
    .pcsrc       (pcsrc),
    .pcen        (pcen),
    .alucontrol  (alucontrol),
    .retire      (retire),
    .retired_cnt (retired_cnt),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check state and full control vector of the current cycle, then advance one cycle
  task automatic cyc(input string tag, input state_t st, input logic [16:0] v);
    #1;
    check({tag, ".state"}, 32'(dut.state_q), 32'(st));
    check({tag, ".ctl"}, 32'(ctl_vec), 32'(v));
    @(negedge clk);
  endtask

  task automatic chk_cnt(input string tag);
    check({tag, ".cnt"}, retired_cnt, exp_cnt);
    $display("%s: retired_cnt=%0d", tag, retired_cnt);
  endtask

  initial begin
    reset = 1'b1; op = OP_LW; funct = F_ADD; zero = 1'b0; exp_cnt = '0;
    @(negedge clk); @(negedge clk);
    cyc("reset", S_FETCH, V_ZERO);
    chk_cnt("reset");
    reset = 1'b0;

    // lw aborted by 2-cycle reset while in MEMRD
    cyc("lwA.fetch", S_FETCH, V_FETCH);
    cyc("lwA.decode", S_DECODE, V_DECODE);
    cyc("lwA.memadr", S_MEMADR, V_MEMADR);
    reset = 1'b1;
    cyc("lwA.rst1", S_MEMRD, V_ZERO);
    cyc("lwA.rst2", S_FETCH, V_ZERO);
    reset = 1'b0;
    chk_cnt("lwA.abort");

    // complete lw: 5 cycles
    cyc("lw.fetch", S_FETCH, V_FETCH);
    cyc("lw.decode", S_DECODE, V_DECODE);
    cyc("lw.memadr", S_MEMADR, V_MEMADR);
    cyc("lw.memrd", S_MEMRD, V_MEMRD);
    cyc("lw.memwb", S_MEMWB, V_MEMWB);
    exp_cnt = 32'd1;
    chk_cnt("lw");

    // R-type add then slt: 4 cycles each
    op = OP_RTYPE; funct = F_ADD;
    cyc("add.fetch", S_FETCH, V_FETCH);
    cyc("add.decode", S_DECODE, V_DECODE);
    cyc("add.execute", S_EXECUTE, V_EXADD);
    cyc("add.aluwb", S_ALUWB, V_ALUWB);
    funct = F_SLT;
    cyc("slt.fetch", S_FETCH, V_FETCH);
    cyc("slt.decode", S_DECODE, V_DECODE);
    cyc("slt.execute", S_EXECUTE, V_EXSLT);
    cyc("slt.aluwb", S_ALUWB, V_ALUWB);
    exp_cnt = 32'd3;
    chk_cnt("add+slt");

    // sw: 4 cycles
    op = OP_SW;
    cyc("sw.fetch", S_FETCH, V_FETCH);
    cyc("sw.decode", S_DECODE, V_DECODE);
    cyc("sw.memadr", S_MEMADR, V_MEMADR);
    cyc("sw.memwr", S_MEMWR, V_MEMWR);
    exp_cnt = 32'd4;
    chk_cnt("sw");

    // addi: 4 cycles
    op = OP_ADDI;
    cyc("addi.fetch", S_FETCH, V_FETCH);
    cyc("addi.decode", S_DECODE, V_DECODE);
    cyc("addi.ex", S_ADDIEX, V_ADDIEX);
    cyc("addi.wb", S_ADDIWB, V_ADDIWB);
    exp_cnt = 32'd5;
    chk_cnt("addi");

    // beq taken then not taken: 3 cycles each
    op = OP_BEQ; zero = 1'b1;
    cyc("beqT.fetch", S_FETCH, V_FETCH);
    cyc("beqT.decode", S_DECODE, V_DECODE);
    cyc("beqT.branch", S_BRANCH, V_BEQT);
    zero = 1'b0;
    cyc("beqN.fetch", S_FETCH, V_FETCH);
    cyc("beqN.decode", S_DECODE, V_DECODE);
    cyc("beqN.branch", S_BRANCH, V_BEQN);
    exp_cnt = 32'd7;
    chk_cnt("beq x2");

    // R-type with unsupported funct goes to ILLEGAL without writeback
    op = OP_RTYPE; funct = 6'b000000;
    cyc("badf.fetch", S_FETCH, V_FETCH);
    cyc("badf.decode", S_DECODE, V_DECODE);
    cyc("badf.execute", S_EXECUTE, V_EXBAD);
    cyc("badf.illegal", S_ILLEGAL, V_ILL);
`ifdef MC_HALT_EN
    cyc("badf.hold", S_ILLEGAL, V_ILL);
    reset = 1'b1;
    cyc("badf.rst", S_ILLEGAL, V_ZERO);
    reset = 1'b0;
    exp_cnt = '0;
`endif
    chk_cnt("badfunct");

    // illegal opcode
    op = 6'b111111; funct = F_ADD;
    cyc("ill.fetch", S_FETCH, V_FETCH);
    cyc("ill.decode", S_DECODE, V_DECODE);
    cyc("ill.illegal", S_ILLEGAL, V_ILL);
`ifdef MC_HALT_EN
    for (int i = 0; i < 9; i++) cyc("ill.hold", S_ILLEGAL, V_ILL);
    reset = 1'b1;
    cyc("ill.rst", S_ILLEGAL, V_ZERO);
    reset = 1'b0;
    exp_cnt = '0;
`endif
    chk_cnt("illegal-op");

    // j with counter preloaded to all-ones: wraps to 0
    op = OP_J;
    force dut.cnt_q = {CNT_W{1'b1}};
    #1;
    release dut.cnt_q;
    exp_cnt = {CNT_W{1'b1}};
    chk_cnt("j.preload");
    cyc("j.fetch", S_FETCH, V_FETCH);
    cyc("j.decode", S_DECODE, V_DECODE);
    cyc("j.jump", S_JUMP, V_JUMP);
    exp_cnt = '0;
    chk_cnt("j.wrap");
    cyc("j.next", S_FETCH, V_FETCH);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
